// File: rtl/vga_scanout.sv
// VGA raster timing generator with an internal pixel-clock divider.
// Emits lookup coordinates and registers the returned colour plus syncs one pixel period later.
module vga_scanout #(
   parameter int CLK_DIV     = 4,
   parameter int FETCH_LAT   = 2,
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter bit SYNC_ACTIVE = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [9:0]  pixel_x,
   output logic [9:0]  pixel_y,
   input  logic [11:0] pixel,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        frame_start,
   output logic        vblank
);

   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   // The pixel must settle before the sampling tick, so the divider has to outlast the fetch.
   if (CLK_DIV <= FETCH_LAT) begin : g_bad_div
      $error("vga_scanout: CLK_DIV must exceed FETCH_LAT");
   end

   logic [DIV_W-1:0] div;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic [9:0]       v_next;
   logic             tick;
   logic             h_wrap;
   logic             v_wrap;
   logic             visible;
   logic             h_sync_zone;
   logic             v_sync_zone;

   assign tick        = (div == DIV_W'(CLK_DIV - 1));
   assign h_wrap      = (h_cnt == 10'(H_TOTAL - 1));
   assign v_wrap      = (v_cnt == 10'(V_TOTAL - 1));
   assign visible     = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
   assign h_sync_zone = (h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END));
   assign v_sync_zone = (v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END));
   assign pixel_x     = h_cnt;
   assign pixel_y     = v_cnt;

   always_comb begin
      v_next = v_cnt;
      if (h_wrap) begin
         v_next = v_wrap ? 10'd0 : v_cnt + 10'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div   <= '0;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         div <= tick ? '0 : div + DIV_W'(1);
         if (tick) begin
            h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
            v_cnt <= v_next;
         end
      end
   end

   // Video outputs describe the period just ending, so they trail the coordinates by one pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_r       <= 4'h0;
         vga_g       <= 4'h0;
         vga_b       <= 4'h0;
         vga_hs      <= ~SYNC_ACTIVE;
         vga_vs      <= ~SYNC_ACTIVE;
         vblank      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= tick && h_wrap && v_wrap;
         if (tick) begin
            vga_r  <= visible ? pixel[11:8] : 4'h0;
            vga_g  <= visible ? pixel[7:4]  : 4'h0;
            vga_b  <= visible ? pixel[3:0]  : 4'h0;
            vga_hs <= h_sync_zone ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vga_vs <= v_sync_zone ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vblank <= (v_next >= 10'(V_VISIBLE));
         end
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster: a lookup model feeds pixels with 2-clock latency and
// an elapsed-clock model predicts every output each cycle, with directed timing measurements on top.
module tb_vga_scanout;

   localparam int DIV = 4;
   localparam int HV = 100, HF = 8, HSY = 12, HB = 10;
   localparam int VV = 20,  VF = 3, VSY = 2,  VB = 5;
   localparam int HT = HV + HF + HSY + HB;
   localparam int VT = VV + VF + VSY + VB;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  pixel_x, pixel_y;
   logic [11:0] pixel;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, frame_start, vblank;

   int          mode = 0;
   int          n = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic [9:0]  d1x, d1y, d2x, d2y;

   vga_scanout #(
      .CLK_DIV(DIV), .FETCH_LAT(2),
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
      .SYNC_ACTIVE(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel(pixel),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .frame_start(frame_start), .vblank(vblank)
   );

   always #5 clk = ~clk;

   // Display lookup: coordinates pass through two registers before the colour appears.
   always @(posedge clk) begin
      d1x <= pixel_x; d1y <= pixel_y;
      d2x <= d1x;     d2y <= d1y;
   end

   always @* begin
      case (mode)
         0:       pixel = {d2x[3:0], d2y[3:0], d2x[7:4]};
         1:       pixel = 12'hFFF;
         2:       pixel = (d2x == pixel_x && d2y == pixel_y) ? 12'h8C4 : 12'h000;
         default: pixel = 12'h000;
      endcase
   end

   // Clocks elapsed since reset release; the whole model is a function of this count.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) n <= 0;
      else        n <= n + 1;
   end

   function automatic logic [35:0] model(input int cnt);
      int         p, q, hq, vq;
      logic [9:0] hx, vy;
      logic [11:0] c;
      logic       hs, vs, fs, vb;
      p = cnt / DIV;
      if (p == 0) return {10'd0, 10'd0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
      q  = p - 1;
      hq = q % HT;
      vq = (q / HT) % VT;
      hx = 10'(hq);
      vy = 10'(vq);
      c  = 12'h000;
      if (hq < HV && vq < VV) begin
         case (mode)
            0:       c = {hx[3:0], vy[3:0], hx[7:4]};
            1:       c = 12'hFFF;
            default: c = 12'h8C4;
         endcase
      end
      hs = !(hq >= HV + HF && hq < HV + HF + HSY);
      vs = !(vq >= VV + VF && vq < VV + VF + VSY);
      vb = ((p / HT) % VT) >= VV;
      fs = (cnt % DIV == 0) && (p % (HT * VT) == 0);
      return {10'(p % HT), 10'((p / HT) % VT), c, hs, vs, fs, vb};
   endfunction

   task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (clock %0d)", name, act, exp, n);
      end
   endtask

   // Every cycle, all outputs are compared with the model.
   always @(negedge clk) begin
      checkOutput("cycle", {pixel_x, pixel_y, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start, vblank},
                  model(n));
   end

   function automatic logic sel(input int which);
      case (which)
         0:       return vga_hs;
         1:       return vga_vs;
         2:       return frame_start;
         3:       return vblank;
         4:       return pixel_x == 10'(HV + HF);
         5:       return pixel_y == 10'(VV + VF) && pixel_x == 10'd0;
         6:       return pixel_y == 10'(VV);
         7:       return pixel_x == 10'h05A && pixel_y == 10'h013;
         8:       return pixel_x == 10'(HV);
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input string name, input int which, input logic val, input int limit,
                           output int stamp);
      int k = 0;
      while (sel(which) !== val && k < limit) begin
         @(negedge clk);
         k++;
      end
      if (sel(which) !== val) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s: timed out after %0d clocks waiting for %0b", name, limit, val);
      end
      stamp = n;
   endtask

   task automatic applyStimulus(input int new_mode);
      @(negedge clk);
      #1 rst_n = 1'b0;
      mode = new_mode;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int t0, t1, t2, t3;
      $display("[TB] starting vga_scanout bench");
      applyStimulus(0);

      repeat (3) @(negedge clk);
      checkOutput("x_before_tick", 36'(pixel_x), 36'd0);
      @(negedge clk);
      checkOutput("x_first_tick", 36'(pixel_x), 36'd1);

      wait_for("x_sync_start", 4, 1'b1, 2000, t0);
      wait_for("hs_fall", 0, 1'b0, 100, t1);
      checkOutput("hs_delay", 36'(t1 - t0), 36'd4);
      wait_for("hs_rise", 0, 1'b1, 200, t2);
      checkOutput("hs_width", 36'(t2 - t1), 36'd48);
      wait_for("hs_fall2", 0, 1'b0, 1000, t3);
      checkOutput("hs_period", 36'(t3 - t1), 36'd520);

      wait_for("xy_5a_13", 7, 1'b1, 12000, t0);
      repeat (4) @(negedge clk);
      checkOutput("capture_r", 36'(vga_r), 36'hA);
      checkOutput("capture_g", 36'(vga_g), 36'h3);
      checkOutput("capture_b", 36'(vga_b), 36'h5);

      wait_for("y_vblank_line", 6, 1'b1, 2000, t0);
      wait_for("vblank_rise", 3, 1'b1, 10, t1);
      checkOutput("vblank_align", 36'(t1 - t0), 36'd0);

      wait_for("y_vsync_line", 5, 1'b1, 4000, t0);
      wait_for("vs_fall", 1, 1'b0, 100, t1);
      checkOutput("vs_delay", 36'(t1 - t0), 36'd4);
      wait_for("vs_rise", 1, 1'b1, 2000, t2);
      checkOutput("vs_width", 36'(t2 - t1), 36'd1040);

      wait_for("fs_first", 2, 1'b1, 4000, t0);
      checkOutput("fs_first_time", 36'(t0), 36'd15600);
      wait_for("fs_low", 2, 1'b0, 5, t1);
      checkOutput("fs_width", 36'(t1 - t0), 36'd1);
      wait_for("fs_second", 2, 1'b1, 16000, t2);
      checkOutput("fs_period", 36'(t2 - t0), 36'd15600);

      // Asynchronous reset dropped between edges while hsync is asserted.
      wait_for("hs_mid_sync", 0, 1'b0, 600, t0);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_xy", {16'd0, pixel_x, pixel_y}, 36'd0);
      checkOutput("rst_rgb", 36'({vga_r, vga_g, vga_b}), 36'h000);
      checkOutput("rst_sync", 36'({vga_hs, vga_vs, frame_start, vblank}), 36'b1100);

      applyStimulus(1);
      wait_for("blank_edge", 8, 1'b1, 1000, t0);
      checkOutput("white_last_vis", 36'({vga_r, vga_g, vga_b}), 36'hFFF);
      repeat (4) @(negedge clk);
      checkOutput("white_first_blank", 36'({vga_r, vga_g, vga_b}), 36'h000);
      repeat (16000) @(negedge clk);

      applyStimulus(2);
      wait_for("margin_edge", 8, 1'b1, 1000, t0);
      checkOutput("margin_rgb", 36'({vga_r, vga_g, vga_b}), 36'h8C4);
      repeat (16000) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
